// File: rtl/fifo_level.sv
// Synchronous sample FIFO with fill level, threshold flags, optional
// first-word-fall-through output, flush and sticky error flags.
module fifo_level #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_TH      = 12,
    parameter int AE_TH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_L    = (ADDR_WIDTH + 1)'(AF_TH);
    localparam logic [ADDR_WIDTH:0]   AE_L    = (ADDR_WIDTH + 1)'(AE_TH);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic rd_acc;
    logic wr_acc;
    logic wr_err;
    logic rd_err;

    // Flags decode the registered level only, so rd/wr never reach them combinationally.
    assign empty        = (level_q == '0);
    assign full         = (level_q == DEPTH_L);
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is only taken when a pop frees a slot in the same cycle.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);
    assign wr_err = wr & ~wr_acc & ~flush;
    assign rd_err = rd & ~rd_acc & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            level_q <= '0;
        end else if (flush) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                level_q <= level_q + LVL_ONE;
            end else if (rd_acc && !wr_acc) begin
                level_q <= level_q - LVL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_acc) begin
            mem[w_ptr] <= w_data;
        end
    end

    // A fresh error in the err_clr cycle keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (overflow_q & ~err_clr) | wr_err;
            underflow_q <= (underflow_q & ~err_clr) | rd_err;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data = empty ? '0 : mem[r_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data_q <= '0;
                end else if (flush) begin
                    r_data_q <= '0;
                end else if (rd_acc) begin
                    r_data_q <= mem[r_ptr];
                end
            end

            assign r_data = r_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: standard and FWFT instances share stimulus and
// are checked against a queue model of the FIFO.
module tb_fifo_level;

    logic        clk = 1'b0;
    logic        reset, wr, rd, flush, err_clr;
    logic [15:0] w_data;
    logic [15:0] r_data0, r_data1;
    logic        empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0]  level;
    logic        f_empty, f_full, f_ae, f_af, f_ov, f_un;
    logic [4:0]  f_level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mq[$];
    logic        m_ov, m_un;
    logic [15:0] m_rd;

    always #5 clk = ~clk;

    fifo_level #(.FWFT(0)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .flush(flush), .err_clr(err_clr), .r_data(r_data0),
        .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_level #(.FWFT(1)) dut_f (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .flush(flush), .err_clr(err_clr), .r_data(r_data1),
        .empty(f_empty), .full(f_full), .almost_empty(f_ae),
        .almost_full(f_af), .level(f_level),
        .overflow(f_ov), .underflow(f_un)
    );

    // Drive one cycle; the model applies the FIFO rules to a queue.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r,
                       input logic fl = 1'b0, input logic ec = 1'b0,
                       input logic rs = 1'b0);
        bit cr, cw;
        wr = w; w_data = d; rd = r; flush = fl; err_clr = ec; reset = rs;
        if (rs) begin
            mq.delete(); m_ov = 0; m_un = 0; m_rd = 0;
        end else begin
            if (ec) begin m_ov = 0; m_un = 0; end
            if (fl) begin
                mq.delete(); m_rd = 0;
            end else begin
                cr = r && mq.size() > 0;
                cw = w && (mq.size() < 16 || cr);
                if (w && !cw) m_ov = 1;
                if (r && !cr) m_un = 1;
                if (cr) m_rd = mq.pop_front();
                if (cw) mq.push_back(d);
            end
        end
        @(posedge clk); #1;
        wr = 0; rd = 0; flush = 0; err_clr = 0; reset = 0;
    endtask

    task automatic test_reset();
        cyc(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({level, empty, full, almost_empty, almost_full} !== {5'd0, 4'b1010}) begin
            n_bad++;
            $display("FAIL reset_flags: got lvl=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0",
                     level, empty, full, almost_empty, almost_full);
        end
        n_cmp++;
        if ({overflow, underflow} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_err: got ov=%b un=%b want 0 0", overflow, underflow);
        end
        n_cmp++;
        if (r_data0 !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h want 0000", r_data0);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 16'(i), 1'b0);
            n_cmp++;
            if (level !== 5'(i) || full !== (i == 16) || almost_full !== (i >= 12)
                || almost_empty !== (i <= 4) || overflow !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_%0d: got lvl=%0d f=%b af=%b ae=%b ov=%b want lvl=%0d",
                         i, level, full, almost_full, almost_empty, overflow, i);
            end
        end
        cyc(1'b1, 16'hFFFF, 1'b0);
        n_cmp++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            n_bad++;
            $display("FAIL fill_overflow: got ov=%b lvl=%0d want ov=1 lvl=16", overflow, level);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 16'h0, 1'b1);
            n_cmp++;
            if (r_data0 !== 16'(i) || level !== 5'(16 - i) || almost_empty !== (16 - i <= 4)
                || empty !== (i == 16)) begin
                n_bad++;
                $display("FAIL drain_%0d: got rd=%h lvl=%0d ae=%b e=%b want rd=%h lvl=%0d",
                         i, r_data0, level, almost_empty, empty, 16'(i), 16 - i);
            end
        end
        cyc(1'b0, 16'h0, 1'b1);
        n_cmp++;
        if (underflow !== 1'b1 || r_data0 !== 16'h0010 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL drain_underflow: got un=%b rd=%h lvl=%0d want 1 0010 0",
                     underflow, r_data0, level);
        end
    endtask

    task automatic test_full_rw();
        logic [15:0] words [16];
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({overflow, underflow} !== 2'b00) begin
            n_bad++;
            $display("FAIL rw_errclr: got ov=%b un=%b want 0 0", overflow, underflow);
        end
        for (int i = 0; i < 16; i++) begin
            words[i] = 16'($urandom);
            cyc(1'b1, words[i], 1'b0);
        end
        cyc(1'b1, 16'hBEEF, 1'b1);
        n_cmp++;
        if (level !== 5'd16 || overflow !== 1'b0 || r_data0 !== words[0]) begin
            n_bad++;
            $display("FAIL rw_full: got lvl=%0d ov=%b rd=%h want 16 0 %h",
                     level, overflow, r_data0, words[0]);
        end
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 16'h0, 1'b1);
            n_cmp++;
            if (r_data0 !== ((i == 16) ? 16'hBEEF : words[i])) begin
                n_bad++;
                $display("FAIL rw_read_%0d: got %h want %h", i, r_data0,
                         (i == 16) ? 16'hBEEF : words[i]);
            end
        end
    endtask

    task automatic test_fwft();
        cyc(1'b1, 16'h00AA, 1'b0);
        n_cmp++;
        if (f_empty !== 1'b0 || r_data1 !== 16'h00AA) begin
            n_bad++;
            $display("FAIL fwft_show: got e=%b rd=%h want 0 00aa", f_empty, r_data1);
        end
        cyc(1'b1, 16'h0055, 1'b0);
        n_cmp++;
        if (r_data1 !== 16'h00AA || f_level !== 5'd2) begin
            n_bad++;
            $display("FAIL fwft_hold: got rd=%h lvl=%0d want 00aa 2", r_data1, f_level);
        end
        cyc(1'b0, 16'h0, 1'b1);
        n_cmp++;
        if (r_data1 !== 16'h0055 || r_data0 !== 16'h00AA) begin
            n_bad++;
            $display("FAIL fwft_pop: got f=%h s=%h want 0055 00aa", r_data1, r_data0);
        end
        cyc(1'b0, 16'h0, 1'b1);
        n_cmp++;
        if (f_empty !== 1'b1 || r_data0 !== 16'h0055) begin
            n_bad++;
            $display("FAIL fwft_last: got e=%b s=%h want 1 0055", f_empty, r_data0);
        end
    endtask

    task automatic test_wrap();
        int nw = 0;
        for (int c = 0; c < 200; c++) begin
            logic w, r;
            w = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) != 0);
            if (w && mq.size() < 16) nw++;
            cyc(w, 16'($urandom), r, 1'b0, ($urandom_range(0, 15) == 0));
            n_cmp++;
            if (level !== 5'(mq.size()) || f_level !== 5'(mq.size())
                || empty !== (mq.size() == 0) || full !== (mq.size() == 16)
                || r_data0 !== m_rd || overflow !== m_ov || underflow !== m_un
                || (mq.size() > 0 && r_data1 !== mq[0])) begin
                n_bad++;
                $display("FAIL wrap_%0d: got lvl=%0d rd=%h fw=%h ov=%b un=%b want lvl=%0d rd=%h ov=%b un=%b",
                         c, level, r_data0, r_data1, overflow, underflow,
                         mq.size(), m_rd, m_ov, m_un);
            end
        end
        n_cmp++;
        if (nw < 20) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d writes want >= 20", nw);
        end
    endtask

    task automatic test_flush();
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        while (mq.size() > 7) cyc(1'b0, 16'h0, 1'b1);
        while (mq.size() < 7) cyc(1'b1, 16'($urandom), 1'b0);
        n_cmp++;
        if (level !== 5'd7) begin
            n_bad++;
            $display("FAIL flush_pre: got lvl=%0d want 7", level);
        end
        cyc(1'b1, 16'h7777, 1'b1, 1'b1);
        n_cmp++;
        if (level !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0
            || overflow !== 1'b0 || r_data0 !== 16'h0) begin
            n_bad++;
            $display("FAIL flush: got lvl=%0d e=%b un=%b ov=%b rd=%h want 0 1 0 0 0000",
                     level, empty, underflow, overflow, r_data0);
        end
        for (int i = 0; i < 16; i++) cyc(1'b1, 16'(i + 100), 1'b0);
        cyc(1'b1, 16'h0BAD, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            n_bad++;
            $display("FAIL errclr_race: got ov=%b lvl=%0d want 1 16", overflow, level);
        end
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({level, empty, full, almost_empty, almost_full, overflow, underflow}
            !== {5'd0, 6'b101000} || r_data0 !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b rd=%h",
                     level, empty, full, almost_empty, almost_full, overflow, underflow, r_data0);
        end
        cyc(1'b1, 16'h1234, 1'b0);
        n_cmp++;
        if (r_data1 !== 16'h1234 || level !== 5'd1) begin
            n_bad++;
            $display("FAIL post_reset: got fw=%h lvl=%0d want 1234 1", r_data1, level);
        end
    endtask

    initial begin
        reset = 1'b1; wr = 0; rd = 0; flush = 0; err_clr = 0; w_data = '0;
        m_ov = 0; m_un = 0; m_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_fwft();
        test_wrap();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
